fifo_write_arbiter: RTL

Round-robin, packet-granular arbiter that shares the single write port of one `fifo` instance among N upstream requesters, such as per-channel signal readers feeding one event-detection stream. Once a requester is granted, it holds the port until its `last` beat is accepted. Packets from different requesters therefore never interleave inside the FIFO, and the FIFO's last-beat tracking stays valid.

---
 rtl/fifo_write_arbiter_if.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals for fifo_write_arbiter.
// The arbiter connects through the slave modport. Upstream requesters and the FIFO model connect through the master modport.
interface fifo_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  logic [N-1:0]       i_req_stb;
  logic [N*WIDTH-1:0] i_req_data;
  logic [N-1:0]       i_req_last;
  logic [N-1:0]       o_req_rdy;
  logic               o_fifo_w_stb;
  logic [WIDTH-1:0]   o_fifo_w_data;
  logic               o_fifo_last_w;
  logic               i_fifo_not_full;
  logic [N-1:0]       o_grant;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_req_stb, i_req_data, i_req_last, i_fifo_not_full,
    output o_req_rdy, o_fifo_w_stb, o_fifo_w_data, o_fifo_last_w,
    output o_grant, o_busy, o_timeout
  );

  modport master (
    output i_req_stb, i_req_data, i_req_last, i_fifo_not_full,
    input  o_req_rdy, o_fifo_w_stb, o_fifo_w_data, o_fifo_last_w,
    input  o_grant, o_busy, o_timeout
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter that shares one FIFO write port among N requesters.
// Optional stall release is enabled by defining ARB_TIMEOUT_EN.
module fifo_write_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_write_arbiter_if.slave  bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_write_arbiter: N must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] cand, pick_idx;
  logic             pick_vld;
  logic             stb_g, last_g, nf, xfer;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Circular search for the first requester after the previous winner.
  always_comb begin
    cand     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(rr_last_q) + k) % N);
      if (!pick_vld && bus.i_req_stb[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign nf     = bus.i_fifo_not_full;
  assign stb_g  = bus.i_req_stb[grant_idx_q];
  assign last_g = bus.i_req_last[grant_idx_q];

  always_comb begin
    state_d            = state_q;
    grant_idx_d        = grant_idx_q;
    rr_last_d          = rr_last_q;
    grant_d            = grant_q;
    xfer               = 1'b0;
    bus.o_req_rdy      = '0;
    bus.o_fifo_w_stb   = 1'b0;
    bus.o_fifo_w_data  = '0;
    bus.o_fifo_last_w  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d              = '0;
    timeout_d          = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_idx_d        = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          state_d            = BUSY;
        end
      end
      BUSY: begin
        xfer                          = stb_g & nf;
        bus.o_req_rdy[grant_idx_q]    = nf;
        bus.o_fifo_w_stb              = xfer;
        bus.o_fifo_w_data             = bus.i_req_data[int'(grant_idx_q)*WIDTH +: WIDTH];
        bus.o_fifo_last_w             = xfer & last_g;
`ifdef ARB_TIMEOUT_EN
        // Only starved-but-writable cycles count. A full FIFO freezes the count.
        if (xfer)              cnt_d = '0;
        else if (nf && !stb_g) cnt_d = cnt_q + 1'b1;
        else                   cnt_d = cnt_q;
`endif
        if (xfer && last_g) begin
          rr_last_d = grant_idx_q;
          grant_d   = '0;
          state_d   = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_d == CNT_W'(TIMEOUT)) begin
          rr_last_d = grant_idx_q;
          grant_d   = '0;
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_last_q   <= IDX_W'(N - 1);
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_last_q   <= rr_last_d;
      grant_q     <= grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_grant = grant_q;
  assign bus.o_busy  = (state_q == BUSY);
endmodule
